// File: rtl/wb_arbiter_if.sv
// Writeback bus between the functional units and the CDB arbiter.
// Each rob_wb_t is packed as {rob_idx[4:0], valid, dest[5:0], result[31:0]}.
interface wb_arbiter_if #(
  parameter int NUM_FU       = 4,
  parameter int ROB_WB_WIDTH = 44,
  parameter int REG_WB_WIDTH = 40
);
  logic [NUM_FU*ROB_WB_WIDTH-1:0] fu_rob_i;
  logic                           mispredict_i;
  logic [ROB_WB_WIDTH-1:0]        cdb_rob_o;
  logic [REG_WB_WIDTH-1:0]        cdb_reg_o;
  logic [NUM_FU-1:0]              fu_full_o;
  logic                           overflow_o;

  modport master (
    output fu_rob_i, mispredict_i,
    input  cdb_rob_o, cdb_reg_o, fu_full_o, overflow_o
  );

  modport slave (
    input  fu_rob_i, mispredict_i,
    output cdb_rob_o, cdb_reg_o, fu_full_o, overflow_o
  );
endinterface

// File: rtl/wb_arbiter.sv
// FU writeback collector: per-FU FIFOs, round-robin grant of one packet per cycle onto the CDB.
// Optional WB_BYPASS_EN: an empty granted FIFO forwards its live input straight to the output.
module wb_arbiter #(
  parameter int NUM_FU     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  wb_arbiter_if.slave bus
);
  localparam int ROB_WB_WIDTH = 44;
  localparam int CDB_W        = 39;
  localparam int VALID_BIT    = 38;
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int CNT_W        = PTR_W + 1;
  localparam int RR_W         = $clog2(NUM_FU);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic [ROB_WB_WIDTH-1:0] in_pkt_p0 [NUM_FU];
  logic [NUM_FU-1:0]       in_vld_p0;
  logic [NUM_FU-1:0]       cand_p0;
  logic [NUM_FU-1:0]       push_p0;
  logic [NUM_FU-1:0]       pop_p0;
  logic [NUM_FU-1:0]       drop_p0;
  logic [NUM_FU-1:0]       full_p0;

  logic [ROB_WB_WIDTH-1:0] fifo_mem [NUM_FU][FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr [NUM_FU];
  logic [PTR_W-1:0]        rd_ptr [NUM_FU];
  logic [CNT_W-1:0]        count  [NUM_FU];

  logic [RR_W-1:0]         rr_ptr;
  logic [RR_W-1:0]         gnt_idx_p0;
  logic                    gnt_vld_p0;
  logic                    bypass_p0;
  logic [ROB_WB_WIDTH-1:0] gnt_pkt_p0;
  logic [ROB_WB_WIDTH-1:0] cdb_p1;
  logic                    overflow_q;

  // Stage p0: unpack inputs, pick a candidate, decide pushes/pops
  always_comb begin
    for (int k = 0; k < NUM_FU; k++) begin
      in_pkt_p0[k] = bus.fu_rob_i[k*ROB_WB_WIDTH +: ROB_WB_WIDTH];
      in_vld_p0[k] = in_pkt_p0[k][VALID_BIT];
      full_p0[k]   = (count[k] == FULL_CNT);
`ifdef WB_BYPASS_EN
      cand_p0[k]   = (count[k] != '0) || in_vld_p0[k];
`else
      cand_p0[k]   = (count[k] != '0);
`endif
    end
  end

  always_comb begin
    logic [RR_W:0]   sum;
    logic [RR_W-1:0] idx;
    gnt_vld_p0 = 1'b0;
    gnt_idx_p0 = '0;
    sum        = '0;
    idx        = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      sum = {1'b0, rr_ptr} + (RR_W+1)'(i);
      if (sum >= (RR_W+1)'(NUM_FU)) sum = sum - (RR_W+1)'(NUM_FU);
      idx = sum[RR_W-1:0];
      if (!gnt_vld_p0 && cand_p0[idx]) begin
        gnt_vld_p0 = 1'b1;
        gnt_idx_p0 = idx;
      end
    end
  end

  // The FIFO head always wins over its own input; the input only bypasses an empty FIFO
  always_comb begin
`ifdef WB_BYPASS_EN
    bypass_p0  = gnt_vld_p0 && (count[gnt_idx_p0] == '0);
    gnt_pkt_p0 = bypass_p0 ? in_pkt_p0[gnt_idx_p0]
                           : fifo_mem[gnt_idx_p0][rd_ptr[gnt_idx_p0]];
`else
    bypass_p0  = 1'b0;
    gnt_pkt_p0 = fifo_mem[gnt_idx_p0][rd_ptr[gnt_idx_p0]];
`endif
  end

  always_comb begin
    logic sel;
    logic accept;
    sel    = 1'b0;
    accept = 1'b0;
    for (int k = 0; k < NUM_FU; k++) begin
      sel        = gnt_vld_p0 && (gnt_idx_p0 == RR_W'(k));
      pop_p0[k]  = sel && (count[k] != '0) && !bus.mispredict_i;
      accept     = in_vld_p0[k] && !bus.mispredict_i && !(sel && bypass_p0);
      push_p0[k] = accept && (!full_p0[k] || pop_p0[k]);
      drop_p0[k] = accept && full_p0[k] && !pop_p0[k];
    end
  end

  // Stage p0 -> p1: FIFO state, round-robin pointer, output register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int k = 0; k < NUM_FU; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
        count[k]  <= '0;
      end
    end else if (bus.mispredict_i) begin
      for (int k = 0; k < NUM_FU; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
        count[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_FU; k++) begin
        if (push_p0[k]) wr_ptr[k] <= wr_ptr[k] + 1'b1;
        if (pop_p0[k])  rd_ptr[k] <= rd_ptr[k] + 1'b1;
        count[k] <= count[k] + {{(CNT_W-1){1'b0}}, push_p0[k]}
                             - {{(CNT_W-1){1'b0}}, pop_p0[k]};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NUM_FU; k++) begin
      if (push_p0[k]) fifo_mem[k][wr_ptr[k]] <= in_pkt_p0[k];
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rr_ptr     <= '0;
      cdb_p1     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (|drop_p0) overflow_q <= 1'b1;
      if (bus.mispredict_i || !gnt_vld_p0) begin
        cdb_p1 <= '0;
      end else begin
        cdb_p1 <= gnt_pkt_p0;
        rr_ptr <= (gnt_idx_p0 == RR_W'(NUM_FU-1)) ? '0 : gnt_idx_p0 + 1'b1;
      end
    end
  end

  // Stage p1: drive the CDB toward ROB and register file
  assign bus.cdb_rob_o  = cdb_p1;
  assign bus.cdb_reg_o  = {cdb_p1[VALID_BIT], cdb_p1[CDB_W-1:0]};
  assign bus.fu_full_o  = full_p0;
  assign bus.overflow_o = overflow_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized scoreboard bench for wb_arbiter: queue-based reference model plus directed scenarios.
module tb_wb_arbiter;
  localparam int N  = 4;
  localparam int D  = 4;
  localparam int W  = 44;
  localparam int VB = 38;
`ifdef WB_BYPASS_EN
  localparam int LAT = 1;
  localparam bit BYP = 1'b1;
`else
  localparam int LAT = 2;
  localparam bit BYP = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic reset_i;
  always #5 clk_i = ~clk_i;

  wb_arbiter_if #(.NUM_FU(N)) bus ();
  wb_arbiter #(.NUM_FU(N), .FIFO_DEPTH(D)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [W-1:0] mq [N][$];
  logic [W-1:0] exp_q [$];
  int           m_rr;
  bit           m_ovf;
  logic [W-1:0] drv [N];
  bit           mon_en = 1'b0;

  function automatic logic [W-1:0] mk(bit v, logic [5:0] dest, logic [31:0] res, logic [4:0] idx);
    return {idx, v, dest, res};
  endfunction

  function automatic bit in_v(int k);
    return bus.fu_rob_i[k*W + VB];
  endfunction

  function automatic logic [W-1:0] in_p(int k);
    return bus.fu_rob_i[k*W +: W];
  endfunction

  function automatic bit model_busy();
    bit b = (exp_q.size() > 0);
    for (int k = 0; k < N; k++) if (mq[k].size() > 0) b = 1'b1;
    return b;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic commit(bit mp);
    for (int k = 0; k < N; k++) bus.fu_rob_i[k*W +: W] = drv[k];
    bus.mispredict_i = mp;
  endtask

  task automatic idle();
    for (int k = 0; k < N; k++) drv[k] = '0;
    commit(1'b0);
  endtask

  task automatic rand_pkt(int k);
    drv[k] = mk(1'b1, 6'($urandom), $urandom, 5'($urandom));
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    idle();
    reset_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0;
  endtask

  task automatic drain(string name);
    int n = 0;
    while (model_busy() && n < 60) begin
      @(negedge clk_i);
      n++;
    end
    check(name, (n < 60), 1);
    repeat (3) @(negedge clk_i);
  endtask

  // Reference model: per-FU queues, round-robin from the last grant, queue of expected CDB packets
  always @(posedge clk_i or posedge reset_i) begin : model
    int g;
    bit popped;
    bit byp;
    logic [W-1:0] pkt;
    if (reset_i) begin
      for (int k = 0; k < N; k++) mq[k].delete();
      exp_q.delete();
      m_rr  = 0;
      m_ovf = 1'b0;
    end else if (bus.mispredict_i) begin
      for (int k = 0; k < N; k++) mq[k].delete();
    end else begin
      g = -1;
      popped = 1'b0;
      byp = 1'b0;
      for (int i = 0; i < N; i++) begin
        int k;
        k = (m_rr + i) % N;
        if (g < 0 && (mq[k].size() > 0 || (BYP && in_v(k)))) g = k;
      end
      if (g >= 0) begin
        if (mq[g].size() > 0) begin
          pkt = mq[g].pop_front();
          popped = 1'b1;
        end else begin
          pkt = in_p(g);
          byp = 1'b1;
        end
        exp_q.push_back(pkt);
        m_rr = (g + 1) % N;
      end
      for (int k = 0; k < N; k++) begin
        if (in_v(k) && !(byp && k == g)) begin
          if (mq[k].size() < D) mq[k].push_back(in_p(k));
          else m_ovf = 1'b1;
        end
      end
    end
  end

  // Monitor: every cycle the CDB must carry exactly the next expected packet, or nothing
  always @(negedge clk_i) begin : monitor
    logic [W-1:0] e;
    logic [N-1:0] fe;
    if (mon_en && !reset_i) begin
      for (int k = 0; k < N; k++) fe[k] = (mq[k].size() == D);
      check("fu_full", bus.fu_full_o, fe);
      check("overflow", bus.overflow_o, m_ovf);
      if (bus.cdb_rob_o[VB]) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_pkt: got %0h expected no packet (t=%0t)", bus.cdb_rob_o, $time);
        end else begin
          e = exp_q.pop_front();
          check("cdb_rob", bus.cdb_rob_o, e);
          check("cdb_reg", bus.cdb_reg_o, {1'b1, e[VB:0]});
        end
      end else begin
        check("cdb_reg_wv", bus.cdb_reg_o[VB+1], 0);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          tests++;
          fails++;
          $display("FAIL missing_pkt: got no packet expected %0h (t=%0t)", e, $time);
        end
      end
    end
  end

  initial begin
    int lat;
    logic [W-1:0] seen;
    reset_i = 1'b1;
    idle();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0;
    check("rst_cdb_rob", bus.cdb_rob_o, 0);
    check("rst_cdb_reg", bus.cdb_reg_o, 0);
    check("rst_full", bus.fu_full_o, 0);
    check("rst_ovf", bus.overflow_o, 0);
    mon_en = 1'b1;

    // Single packet latency
    @(negedge clk_i);
    drv[1] = mk(1'b1, 6'd5, 32'h1234, 5'd3);
    commit(1'b0);
    @(negedge clk_i);
    idle();
    lat = 0;
    seen = '0;
    for (int c = 1; c <= 4; c++) begin
      if (lat == 0 && bus.cdb_rob_o[VB]) begin
        lat = c;
        seen = bus.cdb_rob_o;
      end
      @(negedge clk_i);
    end
    check("t1_latency", lat, LAT);
    check("t1_dest", seen[37:32], 5);
    check("t1_result", seen[31:0], 32'h1234);
    drain("t1_drain");

    // Four simultaneous packets leave in FU order
    do_reset();
    @(negedge clk_i);
    for (int k = 0; k < N; k++) drv[k] = mk(1'b1, 6'(k), $urandom, 5'(k));
    commit(1'b0);
    @(negedge clk_i);
    idle();
    repeat (LAT - 1) @(negedge clk_i);
    for (int k = 0; k < N; k++) begin
      check("t2_valid", bus.cdb_rob_o[VB], 1);
      check("t2_order", bus.cdb_rob_o[37:32], k);
      check("t2_wv", bus.cdb_reg_o[VB+1], 1);
      @(negedge clk_i);
    end
    check("t2_quiet", bus.cdb_rob_o[VB], 0);
    drain("t2_drain");

    // Back-to-back on one FU, popped every cycle
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      drv[0] = mk(1'b1, 6'(i), $urandom, 5'(i));
      commit(1'b0);
    end
    @(negedge clk_i);
    idle();
    drain("t3_drain");
    check("t3_no_ovf", bus.overflow_o, 0);

    // Saturate all FIFOs until packets are dropped
    do_reset();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_i);
      for (int k = 0; k < N; k++) rand_pkt(k);
      commit(1'b0);
      if (c == 6) check("t4_full_any", |bus.fu_full_o, 1);
    end
    @(negedge clk_i);
    idle();
    check("t4_overflow", bus.overflow_o, 1);
    drain("t4_drain");
    check("t4_sticky", bus.overflow_o, 1);

    // Mispredict flushes buffered and incoming packets
    do_reset();
    @(negedge clk_i);
    for (int k = 0; k < 3; k++) rand_pkt(k);
    commit(1'b0);
    @(negedge clk_i);
    idle();
    rand_pkt(2);
    commit(1'b0);
    @(negedge clk_i);
    rand_pkt(2);
    commit(1'b0);
    @(negedge clk_i);
    idle();
    rand_pkt(3);
    commit(1'b1);
    @(negedge clk_i);
    idle();
    check("t5_flush_valid", bus.cdb_rob_o[VB], 0);
    check("t5_flush_full", bus.fu_full_o, 0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_i);
      check("t5_no_stale", bus.cdb_rob_o[VB], 0);
    end

    // Asynchronous reset with data in flight
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      for (int k = 0; k < N; k++) rand_pkt(k);
      commit(1'b0);
    end
    @(negedge clk_i);
    idle();
    @(posedge clk_i);
    #2;
    reset_i = 1'b1;
    #1;
    check("t6_async_rob", bus.cdb_rob_o, 0);
    check("t6_async_reg", bus.cdb_reg_o, 0);
    check("t6_async_full", bus.fu_full_o, 0);
    @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_i);
      check("t6_no_residual", bus.cdb_rob_o[VB], 0);
    end

    // Randomized traffic with occasional mispredicts
    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk_i);
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(99) < 45) rand_pkt(k);
        else drv[k] = '0;
      end
      commit($urandom_range(99) < 4);
    end
    @(negedge clk_i);
    idle();
    drain("rand_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
